rob_occ_array: RTL and testbench

//  Reorder-buffer storage array built from occupied-bit entries. Allocates in order at the tail,

---
 rtl/rob_pkg.sv | 26 ++
 rtl/rob_occ_entry.sv | 68 ++++++
 rtl/rob_occ_array.sv | 141 ++++++++++++++
 tb/tb_rob_occ_array.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the occupied-bit reorder buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rob_pkg;

    // Default geometry of the reorder buffer.
    localparam int P_PTRWIDTH_DEF = 5;
    localparam int P_BITWIDTH_DEF = 32;

    // Number of entries addressed by a pointer of the given width.
    function automatic int rob_depth(input int ptrwidth);
        return 1 << ptrwidth;
    endfunction

    // Pointer and occupancy types for the default geometry.
    // The occupancy counter is one bit wider so that "full" is representable.
    typedef logic [P_PTRWIDTH_DEF-1:0] ptr_t;
    typedef logic [P_PTRWIDTH_DEF:0]   cnt_t;

    typedef struct packed {
        logic                      alloc;
        logic                      occ;
        logic [P_BITWIDTH_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/rob_occ_entry.sv
// One reorder-buffer entry: alloc bit, occupied bit and payload register.
// Latency: every update becomes visible one cycle after its strobe.
// Backpressure: none; the strobes are qualified by the parent.
//
// Ports: clk/rst (sync, active-high); set_alloc marks the entry allocated and
// empty; wr/wr_data complete it (ignored unless already allocated); clr frees
// it on dequeue; flush frees it while keeping the payload; alloc/occ/data
// expose the registered state.
module rob_occ_entry
    import rob_pkg::*;
#(
    parameter int p_bitwidth = P_BITWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_alloc,
    input  logic                  wr,
    input  logic [p_bitwidth-1:0] wr_data,
    input  logic                  clr,
    input  logic                  flush,
    output logic                  alloc,
    output logic                  occ,
    output logic [p_bitwidth-1:0] data
);

    typedef struct packed {
        logic                  alloc;
        logic                  occ;
        logic [p_bitwidth-1:0] data;
    } ent_t;

    ent_t ent_q;
    ent_t ent_d;

    // A dequeue beats a completion write to the same entry: the old payload
    // has already been handed to commit and the slot is being freed.
    // A write can only land on an entry that was allocated in a previous
    // cycle, so a write racing its own allocation is dropped.
    always_comb begin
        ent_d = ent_q;
        if (flush) begin
            ent_d.alloc = 1'b0;
            ent_d.occ   = 1'b0;
        end else if (clr) begin
            ent_d.alloc = 1'b0;
            ent_d.occ   = 1'b0;
        end else if (set_alloc) begin
            ent_d.alloc = 1'b1;
            ent_d.occ   = 1'b0;
        end else if (wr && ent_q.alloc) begin
            ent_d.occ  = 1'b1;
            ent_d.data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign alloc = ent_q.alloc;
    assign occ   = ent_q.occ;
    assign data  = ent_q.data;

endmodule

// File: rtl/rob_occ_array.sv
// Reorder buffer: in-order allocate at tail, out-of-order complete by index, in-order retire at head.
// Latency: alloc/write/dequeue take effect next cycle; deq outputs are combinational from state (no bypass).
// Backpressure: alloc_rdy drops while full (even if head retires); deq holds until deq_rdy.
//
// Ports: clk, rst (sync, active-high); alloc_val/alloc_rdy/alloc_idx dispatch
// side; wr_en/wr_idx/wr_data completion writes; deq_val/deq_rdy/deq_data/deq_idx
// commit side; flush drops every entry; count is the number allocated; err is
// a sticky protocol-error flag.
// Build option: define ROB_WR_CHECK_EN to enable the protocol checker driving
// err; otherwise err is tied low.
module rob_occ_array
    import rob_pkg::*;
#(
    parameter int p_ptrwidth = P_PTRWIDTH_DEF,
    parameter int p_bitwidth = P_BITWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_val,
    output logic                  alloc_rdy,
    output logic [p_ptrwidth-1:0] alloc_idx,
    input  logic                  wr_en,
    input  logic [p_ptrwidth-1:0] wr_idx,
    input  logic [p_bitwidth-1:0] wr_data,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [p_bitwidth-1:0] deq_data,
    output logic [p_ptrwidth-1:0] deq_idx,
    input  logic                  flush,
    output logic [p_ptrwidth:0]   count,
    output logic                  err
);

    localparam int DEPTH = rob_depth(p_ptrwidth);
    localparam int CW    = p_ptrwidth + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [p_ptrwidth-1:0] head_q, head_d;
    logic [p_ptrwidth-1:0] tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic [DEPTH-1:0]      alloc_vec;
    logic [DEPTH-1:0]      occ_vec;
    logic [p_bitwidth-1:0] data_arr [DEPTH];

    logic full;
    logic alloc_fire;
    logic deq_fire;

    // Full/empty comes from the counter; head == tail is ambiguous.
    assign full       = (count_q == DEPTH_C);
    assign alloc_rdy  = ~full;
    assign alloc_idx  = tail_q;
    assign alloc_fire = alloc_val & alloc_rdy;

    assign deq_val  = alloc_vec[head_q] & occ_vec[head_q];
    assign deq_idx  = head_q;
    assign deq_data = data_arr[head_q];
    assign deq_fire = deq_val & deq_rdy;

    assign count = count_q;

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + p_ptrwidth'(1);
            end
            if (deq_fire) begin
                head_d = head_q + p_ptrwidth'(1);
            end
            if (alloc_fire && !deq_fire) begin
                count_d = count_q + CW'(1);
            end else if (!alloc_fire && deq_fire) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rob_occ_entry #(
            .p_bitwidth (p_bitwidth)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .set_alloc (alloc_fire && (tail_q == p_ptrwidth'(i))),
            .wr        (wr_en && (wr_idx == p_ptrwidth'(i))),
            .wr_data   (wr_data),
            .clr       (deq_fire && (head_q == p_ptrwidth'(i))),
            .flush     (flush),
            .alloc     (alloc_vec[i]),
            .occ       (occ_vec[i]),
            .data      (data_arr[i])
        );
    end

`ifdef ROB_WR_CHECK_EN
    logic err_q, err_d;
    logic wr_bad;

    // Writes must target an allocated, not-yet-completed entry; dispatch must
    // not request while full. Only rst clears the flag.
    assign wr_bad = wr_en & (~alloc_vec[wr_idx] | occ_vec[wr_idx]);

    always_comb begin
        err_d = err_q | wr_bad | (alloc_val & full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rob_occ_array.sv
// Directed bench for rob_occ_array (DEPTH=4, 8-bit payload) with a scoreboard:
// stimulus pushes expected grants, retirements and status snapshots onto queues,
// and one monitor process on the falling edge pops and compares them.
module tb_rob_occ_array;

    localparam int PW = 2;
    localparam int BW = 8;
`ifdef ROB_WR_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_val;
    logic          alloc_rdy;
    logic [PW-1:0] alloc_idx;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [BW-1:0] wr_data;
    logic          deq_val;
    logic          deq_rdy;
    logic [BW-1:0] deq_data;
    logic [PW-1:0] deq_idx;
    logic          flush;
    logic [PW:0]   count;
    logic          err;

    rob_occ_array #(
        .p_ptrwidth (PW),
        .p_bitwidth (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_val (alloc_val),
        .alloc_rdy (alloc_rdy),
        .alloc_idx (alloc_idx),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .deq_val   (deq_val),
        .deq_rdy   (deq_rdy),
        .deq_data  (deq_data),
        .deq_idx   (deq_idx),
        .flush     (flush),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } deq_t;

    typedef struct {
        int cnt;
        bit rdy;
        bit dval;
        bit err;
        int aidx;
    } stat_t;

    int    alloc_q[$];
    deq_t  deq_q[$];
    stat_t stat_q[$];
    string name_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit done   = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stat(input string n, input int c, input bit r, input bit d,
                               input bit e, input int a);
        stat_t s;
        s.cnt  = c;
        s.rdy  = r;
        s.dval = d;
        s.err  = e;
        s.aidx = a;
        stat_q.push_back(s);
        name_q.push_back(n);
    endtask

    task automatic push_deq(input int idx, input int data);
        deq_t t;
        t.idx  = idx;
        t.data = data;
        deq_q.push_back(t);
    endtask

    task automatic wr(input bit en, input int idx, input int data);
        wr_en   = en;
        wr_idx  = PW'(idx);
        wr_data = BW'(data);
    endtask

    // Monitor / checker: sole owner of the check counters.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc > 2000) begin
            $display("FAIL watchdog: cycle=%0d, required done before 2000", cyc);
            $fatal(1, "watchdog expired");
        end
        if (stat_q.size() > 0) begin
            stat_t s;
            string n;
            s = stat_q.pop_front();
            n = name_q.pop_front();
            checks = checks + 1;
            if (int'(count) != s.cnt || alloc_rdy !== s.rdy || deq_val !== s.dval ||
                err !== s.err || int'(alloc_idx) != s.aidx) begin
                errors = errors + 1;
                $display("FAIL %s: got count=%0d rdy=%0b dval=%0b err=%0b aidx=%0d, want count=%0d rdy=%0b dval=%0b err=%0b aidx=%0d",
                         n, count, alloc_rdy, deq_val, err, alloc_idx,
                         s.cnt, s.rdy, s.dval, s.err, s.aidx);
            end
        end
        if (alloc_val && alloc_rdy && !rst) begin
            checks = checks + 1;
            if (alloc_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL alloc_grant: unexpected grant idx=%0d, want no grant", alloc_idx);
            end else begin
                int e;
                e = alloc_q.pop_front();
                if (int'(alloc_idx) != e) begin
                    errors = errors + 1;
                    $display("FAIL alloc_idx: got %0d, want %0d", alloc_idx, e);
                end
            end
        end
        if (deq_val && deq_rdy && !rst) begin
            checks = checks + 1;
            if (deq_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL deq: unexpected retire idx=%0d data=%02h, want none", deq_idx, deq_data);
            end else begin
                deq_t t;
                t = deq_q.pop_front();
                if (int'(deq_idx) != t.idx || int'(deq_data) != t.data) begin
                    errors = errors + 1;
                    $display("FAIL deq: got idx=%0d data=%02h, want idx=%0d data=%02h",
                             deq_idx, deq_data, t.idx, t.data);
                end
            end
        end
        if (done) begin
            checks = checks + 1;
            if (alloc_q.size() != 0 || deq_q.size() != 0 || stat_q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain: got alloc=%0d deq=%0d stat=%0d pending, want 0",
                         alloc_q.size(), deq_q.size(), stat_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; alloc_val = 1'b0; deq_rdy = 1'b0; flush = 1'b0;
        wr(1'b0, 0, 0);
        step(); step();
        rst = 1'b0;
        expect_stat("reset", 0, 1, 0, 0, 0);
        step();

        // 1: fill, then a request while full is refused.
        for (int i = 0; i < 4; i++) begin
            alloc_val = 1'b1;
            alloc_q.push_back(i);
            expect_stat("t1_alloc", i, 1, 0, 0, i);
            step();
        end
        expect_stat("t1_full_req", 4, 0, 0, 0, 0);
        step();
        alloc_val = 1'b0;
        expect_stat("t1_full", 4, 0, 0, EN, 0);
        step();
        rst = 1'b1; step(); rst = 1'b0;

        // 2: out-of-order completion, in-order retire.
        for (int i = 0; i < 3; i++) begin
            alloc_val = 1'b1;
            alloc_q.push_back(i);
            step();
        end
        alloc_val = 1'b0;
        wr(1'b1, 2, 8'h22); expect_stat("t2_wr2", 3, 1, 0, 0, 3); step();
        wr(1'b1, 0, 8'h00); expect_stat("t2_wr0", 3, 1, 0, 0, 3); step();
        wr(1'b1, 1, 8'h11); expect_stat("t2_wr1", 3, 1, 1, 0, 3); step();
        wr(1'b0, 0, 0);
        deq_rdy = 1'b1;
        push_deq(0, 8'h00); push_deq(1, 8'h11); push_deq(2, 8'h22);
        step(); step(); step();
        deq_rdy = 1'b0;
        expect_stat("t2_empty", 0, 1, 0, 0, 3);
        step();
        rst = 1'b1; step(); rst = 1'b0;

        // 3: streaming alloc/complete/retire across the wrap.
        for (int k = 0; k < 8; k++) begin
            int na;
            na = (k < 6) ? k : 6;
            alloc_val = (k < 6);
            if (k < 6) alloc_q.push_back(k % 4);
            wr(k >= 1 && k <= 6, (k + 3) % 4, 8'h30 + k - 1);
            deq_rdy = 1'b1;
            if (k >= 2) push_deq((k - 2) % 4, 8'h30 + k - 2);
            expect_stat("t3_wrap", na - ((k < 2) ? 0 : k - 2), 1, k >= 2, 0, na % 4);
            step();
        end
        alloc_val = 1'b0; deq_rdy = 1'b0; wr(1'b0, 0, 0);
        expect_stat("t3_end", 0, 1, 0, 0, 2);
        step();

        // 4: full with a retiring head still refuses the allocation.
        for (int i = 0; i < 4; i++) begin
            alloc_val = 1'b1;
            alloc_q.push_back((i + 2) % 4);
            step();
        end
        alloc_val = 1'b0;
        wr(1'b1, 2, 8'h44); expect_stat("t4_full", 4, 0, 0, 0, 2); step();
        wr(1'b0, 0, 0);
        alloc_val = 1'b1; deq_rdy = 1'b1;
        push_deq(2, 8'h44);
        expect_stat("t4_both", 4, 0, 1, 0, 2);
        step();
        alloc_val = 1'b0; deq_rdy = 1'b0;
        expect_stat("t4_after", 3, 1, 0, EN, 2);
        step();
        rst = 1'b1; step(); rst = 1'b0;

        // 5: write to an unallocated entry is dropped.
        wr(1'b1, 3, 8'h99); expect_stat("t5_badwr", 0, 1, 0, 0, 0); step();
        wr(1'b0, 0, 0);     expect_stat("t5_err", 0, 1, 0, EN, 0); step();
        for (int i = 0; i < 4; i++) begin
            alloc_val = 1'b1;
            alloc_q.push_back(i);
            expect_stat("t5_alloc", i, 1, 0, EN, i);
            step();
        end
        alloc_val = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wr(1'b1, j, 8'hA0 + j);
            expect_stat("t5_wr", 4, 0, j >= 1, EN, 0);
            step();
        end
        wr(1'b0, 0, 0);
        deq_rdy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            push_deq(j, 8'hA0 + j);
            expect_stat("t5_deq", 4 - j, j > 0, 1, EN, 0);
            step();
        end
        expect_stat("t5_wait3", 1, 1, 0, EN, 0); step();
        wr(1'b1, 3, 8'hB3); expect_stat("t5_wr3", 1, 1, 0, EN, 0); step();
        wr(1'b0, 0, 0);
        push_deq(3, 8'hB3);
        expect_stat("t5_deq3", 1, 1, 1, EN, 0); step();
        deq_rdy = 1'b0;
        expect_stat("t5_end", 0, 1, 0, EN, 0); step();

        // 6: same-cycle alloc+write dropped, then flush with 3 entries, 2 completed.
        alloc_val = 1'b1; alloc_q.push_back(0);
        wr(1'b1, 0, 8'h55); expect_stat("t6_c1", 0, 1, 0, EN, 0); step();
        alloc_q.push_back(1);
        wr(1'b1, 0, 8'h66); expect_stat("t6_c2", 1, 1, 0, EN, 1); step();
        alloc_q.push_back(2);
        wr(1'b1, 1, 8'h77); expect_stat("t6_c3", 2, 1, 1, EN, 2); step();
        alloc_val = 1'b0; deq_rdy = 1'b1; push_deq(0, 8'h66);
        wr(1'b1, 2, 8'h88); expect_stat("t6_c4", 3, 1, 1, EN, 3); step();
        deq_rdy = 1'b0; alloc_val = 1'b1; alloc_q.push_back(3);
        wr(1'b0, 0, 0);     expect_stat("t6_c5", 2, 1, 1, EN, 3); step();
        alloc_val = 1'b0; flush = 1'b1;
        expect_stat("t6_flush", 3, 1, 1, EN, 0); step();
        flush = 1'b0;
        expect_stat("t6_flushed", 0, 1, 0, EN, 0); step();
        rst = 1'b1; step(); rst = 1'b0;
        expect_stat("t6_rst", 0, 1, 0, 0, 0); step();
        done = 1'b1;
        step();
        step();
    end

endmodule
